// File: rtl/ssd1306_pkg.sv
// Shared types and constants for the SSD1306 bring-up datapath:
// init FSM states and the layout of the 9-bit init ROM word.
package ssd1306_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RES_LOW  = 3'd1,
    RES_WAIT = 3'd2,
    FETCH    = 3'd3,
    SEND     = 3'd4,
    DONE     = 3'd5
  } init_state_t;

  localparam int ROM_DATA_WIDTH = 9;
  localparam int ROM_DC_BIT     = 8;

  localparam logic CMD_DC  = 1'b0;
  localparam logic DATA_DC = 1'b1;

endpackage

// File: rtl/ssd1306_init_sequencer_if.sv
// Byte stream from the init sequencer to the SPI serializer:
// one byte plus its D/C level, moved on tx_valid && tx_ready.
interface ssd1306_init_sequencer_if;

  logic       tx_valid;
  logic [7:0] tx_byte;
  logic       tx_dc;
  logic       tx_ready;

  modport master (
    output tx_valid,
    output tx_byte,
    output tx_dc,
    input  tx_ready
  );

  modport slave (
    input  tx_valid,
    input  tx_byte,
    input  tx_dc,
    output tx_ready
  );

endinterface

// File: rtl/ssd1306_init_sequencer_delay_counter.sv
// Saturating up-counter with synchronous clear and a terminal-count flag
// against a caller-supplied value; shared by the panel timing stages.
module delay_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             enable_i,
  input  logic [WIDTH-1:0] terminal_i,
  output logic             terminal_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Clear wins over enable; the count parks at all-ones instead of wrapping.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign terminal_o = (count_q == terminal_i);

endmodule

// File: rtl/ssd1306_init_sequencer.sv
// SSD1306 power-up sequencer: pulses the panel reset pin, waits for the
// panel to settle, then streams the init ROM to the SPI byte transmitter.
module ssd1306_init_sequencer
  import ssd1306_pkg::*;
#(
  parameter int ROM_SIZE          = 25,
  parameter int ADDRESS_BITS      = $clog2(ROM_SIZE),
  parameter int RESET_LOW_CYCLES  = 10,
  parameter int RESET_WAIT_CYCLES = 100
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  output logic [ADDRESS_BITS-1:0]   rom_address,
  input  logic [ROM_DATA_WIDTH-1:0] rom_data,
  input  logic                      rom_last,
  output logic                      oled_res_n,
  ssd1306_init_sequencer_if.master  tx,
  output logic                      busy,
  output logic                      done
);

  localparam int CNT_MAX = (RESET_LOW_CYCLES > RESET_WAIT_CYCLES) ?
                           RESET_LOW_CYCLES : RESET_WAIT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]        LOW_TC   = CNT_W'(RESET_LOW_CYCLES - 1);
  localparam logic [CNT_W-1:0]        WAIT_TC  = CNT_W'(RESET_WAIT_CYCLES - 1);
  localparam logic [ADDRESS_BITS-1:0] ADDR_END = ADDRESS_BITS'(ROM_SIZE);

  init_state_t state_q, state_d;

  logic [ADDRESS_BITS-1:0] addr_q, addr_d;
  logic [7:0]              byte_q, byte_d;
  logic                    dc_q, dc_d;
  logic                    valid_q, valid_d;
  logic                    res_n_q, res_n_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  logic             cnt_clr;
  logic             cnt_en;
  logic [CNT_W-1:0] cnt_terminal;
  logic             cnt_tc;
  logic             handshake;

  assign handshake = valid_q && tx.tx_ready;

  delay_counter #(
    .WIDTH (CNT_W)
  ) u_delay (
    .clk        (clk),
    .reset      (reset),
    .clear_i    (cnt_clr),
    .enable_i   (cnt_en),
    .terminal_i (cnt_terminal),
    .terminal_o (cnt_tc)
  );

  // State and output registers; every port is driven straight from a flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      byte_q  <= '0;
      dc_q    <= 1'b0;
      valid_q <= 1'b0;
      res_n_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      byte_q  <= byte_d;
      dc_q    <= dc_d;
      valid_q <= valid_d;
      res_n_q <= res_n_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) state_d = RES_LOW;
      end
      RES_LOW: begin
        if (cnt_tc) state_d = RES_WAIT;
      end
      RES_WAIT: begin
        if (cnt_tc) state_d = FETCH;
      end
      FETCH: begin
        state_d = rom_last ? DONE : SEND;
      end
      SEND: begin
        if (handshake) state_d = FETCH;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output flops are loaded from the next state so they line up with it.
  always_comb begin
    addr_d       = addr_q;
    byte_d       = byte_q;
    dc_d         = dc_q;
    cnt_clr      = 1'b0;
    cnt_en       = 1'b0;
    cnt_terminal = LOW_TC;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          addr_d  = '0;
          cnt_clr = 1'b1;
        end
      end
      RES_LOW: begin
        cnt_en = 1'b1;
        if (cnt_tc) cnt_clr = 1'b1;
      end
      RES_WAIT: begin
        cnt_en       = 1'b1;
        cnt_terminal = WAIT_TC;
      end
      FETCH: begin
        if (!rom_last) begin
          byte_d = rom_data[7:0];
          dc_d   = rom_data[ROM_DC_BIT];
        end
      end
      SEND: begin
        if (handshake && (addr_q != ADDR_END)) addr_d = addr_q + 1'b1;
      end
      default: ;
    endcase

    res_n_d = (state_d != RES_LOW);
    valid_d = (state_d == SEND);
    busy_d  = (state_d == RES_LOW) || (state_d == RES_WAIT) ||
              (state_d == FETCH)   || (state_d == SEND);
    done_d  = (state_d == DONE);
  end

  assign rom_address = addr_q;
  assign oled_res_n  = res_n_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign tx.tx_valid = valid_q;
  assign tx.tx_byte  = byte_q;
  assign tx.tx_dc    = dc_q;

endmodule

// File: tb/tb_ssd1306_init_sequencer.sv
// Bench for ssd1306_init_sequencer: directed sequences with a handshake
// scoreboard, plus a second instance wired to an empty ROM.
module tb_ssd1306_init_sequencer;
  import ssd1306_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [4:0] rom_address;
  logic [8:0] rom_data;
  logic       rom_last;
  logic       oled_res_n;
  logic       busy;
  logic       done;

  logic       start_e;
  logic [0:0] rom_address_e;
  logic       oled_res_n_e;
  logic       busy_e;
  logic       done_e;

  ssd1306_init_sequencer_if txif ();
  ssd1306_init_sequencer_if txe ();

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int hs_count = 0;
  int last_hs_cyc = 0;
  logic [13:0] exp_q [$];

  localparam logic [17:0] RESET_VEC = 18'h20000;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [8:0] rom_word(input logic [4:0] a);
    case (a)
      5'd0:  return {CMD_DC, 8'hAE};   5'd1:  return {CMD_DC, 8'hD5};
      5'd2:  return {CMD_DC, 8'h80};   5'd3:  return {DATA_DC, 8'hA8};
      5'd4:  return {CMD_DC, 8'h3F};   5'd5:  return {CMD_DC, 8'hD3};
      5'd6:  return {CMD_DC, 8'h00};   5'd7:  return {CMD_DC, 8'h40};
      5'd8:  return {CMD_DC, 8'h8D};   5'd9:  return {CMD_DC, 8'h14};
      5'd10: return {CMD_DC, 8'h20};   5'd11: return {CMD_DC, 8'h00};
      5'd12: return {CMD_DC, 8'hA1};   5'd13: return {CMD_DC, 8'hC8};
      5'd14: return {CMD_DC, 8'hDA};   5'd15: return {CMD_DC, 8'h12};
      5'd16: return {CMD_DC, 8'h81};   5'd17: return {CMD_DC, 8'hCF};
      5'd18: return {CMD_DC, 8'hD9};   5'd19: return {CMD_DC, 8'hF1};
      5'd20: return {CMD_DC, 8'hDB};   5'd21: return {CMD_DC, 8'h40};
      5'd22: return {CMD_DC, 8'hA4};   5'd23: return {CMD_DC, 8'hA6};
      5'd24: return {DATA_DC, 8'hAF};
      default: return 9'h000;
    endcase
  endfunction

  assign rom_data = rom_word(rom_address);
  assign rom_last = (rom_address == 5'd25);

  ssd1306_init_sequencer #(
    .ROM_SIZE (25), .RESET_LOW_CYCLES (10), .RESET_WAIT_CYCLES (100)
  ) dut (
    .clk (clk), .reset (reset), .start (start),
    .rom_address (rom_address), .rom_data (rom_data), .rom_last (rom_last),
    .oled_res_n (oled_res_n), .tx (txif.master), .busy (busy), .done (done)
  );

  ssd1306_init_sequencer #(
    .ROM_SIZE (1), .ADDRESS_BITS (1), .RESET_LOW_CYCLES (10), .RESET_WAIT_CYCLES (100)
  ) dut_e (
    .clk (clk), .reset (reset), .start (start_e),
    .rom_address (rom_address_e), .rom_data (9'h1AA), .rom_last (1'b1),
    .oled_res_n (oled_res_n_e), .tx (txe.master), .busy (busy_e), .done (done_e)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [17:0] outvec();
    return {oled_res_n, busy, done, txif.tx_valid, txif.tx_dc, txif.tx_byte, rom_address};
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push_all();
    for (int i = 0; i < 25; i++) exp_q.push_back({5'(i), rom_word(5'(i))});
  endtask

  // Scoreboard monitor: every accepted byte must match the next expected entry.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && txif.tx_valid && txif.tx_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_handshake: got addr %0d word 0x%0h, expected none",
                   rom_address, {txif.tx_dc, txif.tx_byte});
        end else begin
          check("tx_word", {rom_address, txif.tx_dc, txif.tx_byte}, exp_q.pop_front());
        end
        hs_count++;
        last_hs_cyc = cyc;
      end
    end
  end

  task automatic run_sequence(input bit pulse_busy, input bit backpressure);
    int k = 0, n_low = 0, first_low = -1, last_low = -1, first_valid = -1;
    int bp_cnt = 0, done_cyc = 0;
    bit seen_done = 0, bp_active = 0, bp_finished = 0;
    hs_count = 0;
    push_all();
    start = 1'b1;
    while (k < 700 && !seen_done) begin
      tick();
      k++;
      start = pulse_busy && (k == 50 || k == 130);
      if (k == 1) begin
        check("busy_after_start", busy, 1);
        check("done_clear_after_start", done, 0);
      end
      if (!oled_res_n) begin
        n_low++;
        if (first_low < 0) first_low = k;
        last_low = k;
      end
      if (txif.tx_valid && first_valid < 0) first_valid = k;
      if (backpressure && !bp_finished) begin
        if (!bp_active && busy && rom_address == 5'd3 && !txif.tx_valid) begin
          txif.tx_ready = 1'b0;
          bp_active = 1;
        end else if (bp_active) begin
          check("stall_hold", {txif.tx_valid, txif.tx_dc, txif.tx_byte, rom_address},
                {1'b1, rom_word(5'd3), 5'd3});
          bp_cnt++;
          if (bp_cnt == 7) begin
            check("stall_no_handshake", hs_count, 3);
            @(posedge clk);
            #1;
            txif.tx_ready = 1'b1;
            bp_active = 0;
            bp_finished = 1;
          end
        end
      end
      if (done) begin
        seen_done = 1;
        done_cyc = cyc;
      end
    end
    start = 1'b0;
    check("done_seen", seen_done, 1);
    check("oled_low_count", n_low, 10);
    check("oled_first_low", first_low, 1);
    check("oled_last_low", last_low, 10);
    check("first_valid_cycle", first_valid, 112);
    check("handshake_count", hs_count, 25);
    check("done_after_last_hs", done_cyc - last_hs_cyc, 2);
    check("busy_at_done", busy, 0);
    check("queue_drained", exp_q.size(), 0);
  endtask

  task automatic run_interrupted();
    int k = 0;
    bit found = 0;
    hs_count = 0;
    push_all();
    start = 1'b1;
    while (k < 400 && !found) begin
      tick();
      k++;
      start = 1'b0;
      if (busy && rom_address == 5'd12 && !txif.tx_valid) found = 1;
    end
    check("reached_byte12", found, 1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    tick();
    check("byte12_presented", {txif.tx_valid, txif.tx_dc, txif.tx_byte, rom_address},
          {1'b1, rom_word(5'd12), 5'd12});
    check("hs_before_reset", hs_count, 12);
    tick();
    check("reset_mid_sequence", outvec(), RESET_VEC);
    check("dropped_entries", exp_q.size(), 13);
    reset = 1'b0;
    exp_q.delete();
    run_sequence(1'b0, 1'b0);
  endtask

  task automatic run_empty();
    int k = 0, n_low = 0, first_low = -1, hs_e = 0, done_k = -1;
    start_e = 1'b1;
    while (k < 300 && !(done_k >= 0 && k > done_k + 3)) begin
      tick();
      k++;
      start_e = 1'b0;
      if (!oled_res_n_e) begin
        n_low++;
        if (first_low < 0) first_low = k;
      end
      if (txe.tx_valid) hs_e++;
      if (done_e && done_k < 0) done_k = k;
    end
    check("empty_oled_low_count", n_low, 10);
    check("empty_oled_first_low", first_low, 1);
    check("empty_handshakes", hs_e, 0);
    check("empty_done_cycle", done_k, 112);
    check("empty_idle_after", {busy_e, done_e, rom_address_e}, 3'b010);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    start_e = 1'b0;
    txif.tx_ready = 1'b1;
    txe.tx_ready = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle_outputs", outvec(), RESET_VEC);
    end
    check("idle_outputs_empty", {oled_res_n_e, busy_e, done_e, txe.tx_valid, rom_address_e},
          5'b10000);
    run_sequence(1'b1, 1'b0);
    run_sequence(1'b0, 1'b1);
    run_interrupted();
    run_empty();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at time %0t, expected completion", $time);
    $fatal(1);
  end

endmodule
